// File: rtl/fft_engine_seq.sv
// fft_engine_seq: in-place radix-2 DIT FFT that runs every stage through one time-multiplexed butterfly
// Ports: clk, reset (synchronous, active-high);
//   in_valid/in_ready/in_data/in_inverse  sample stream in natural order, in_inverse taken with the first sample;
//   out_valid/out_ready/out_data/out_last bin stream in natural order, out_last on bin SAMPLES-1;
//   tw_idx/tw_in  twiddle lookup, W=exp(-j2*pi*k/SAMPLES), answered combinationally;
//   busy  high while a frame is being loaded, computed or unloaded.
module fft_engine_seq #(
  parameter int SAMPLES = 8,
  parameter int WIDTH = 32,
  parameter bit SCALE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_inverse,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_last,
  output logic [$clog2(SAMPLES)-2:0]   tw_idx,
  input  logic [WIDTH-1:0]             tw_in,
  output logic                         busy
);
  localparam int L = $clog2(SAMPLES);
  localparam int BW = L - 1;
  localparam int SW = $clog2(L);
  localparam int H = WIDTH / 2;
  localparam int U = H + 1;
  localparam int D = 2 * H;
  localparam int S = 2 * H + 1;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;
  state_t state_q;
  logic [L-1:0] cnt_q;
  logic [BW-1:0] bfly_q;
  logic [SW-1:0] stage_q;
  logic inv_q, out_valid_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] mem_q [SAMPLES];
  logic [L-1:0] b_w, j, top, bot;
  logic signed [H-1:0] ar, ai, br, bi, wr, wi, tr, ti;
  logic signed [D-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [S-1:0] sr, si;
  logic signed [U-1:0] ur, ui, vr, vi;
  logic [WIDTH-1:0] top_n, bot_n;

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
    for (int i = 0; i < L; i++) bitrev[i] = x[L-1-i];
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;

  always_comb begin
    b_w = L'(bfly_q);
    j = b_w & ((L'(1) << stage_q) - L'(1));
    top = ((b_w >> stage_q) << (32'(stage_q) + 1)) | j;
    bot = top | (L'(1) << stage_q);
    tw_idx = (state_q == COMPUTE) ? BW'(j << (L - 1 - 32'(stage_q))) : '0;
    ar = mem_q[top][WIDTH-1:H];
    ai = mem_q[top][H-1:0];
    br = mem_q[bot][WIDTH-1:H];
    bi = mem_q[bot][H-1:0];
    wr = tw_in[WIDTH-1:H];
    // inverse transform uses the conjugate twiddle
    wi = inv_q ? -tw_in[H-1:0] : tw_in[H-1:0];
    p_rr = D'(br) * D'(wr);
    p_ii = D'(bi) * D'(wi);
    p_ri = D'(br) * D'(wi);
    p_ir = D'(bi) * D'(wr);
    sr = S'(p_rr) - S'(p_ii);
    si = S'(p_ri) + S'(p_ir);
    tr = H'(sr >>> (H - 1));
    ti = H'(si >>> (H - 1));
    ur = U'(ar) + U'(tr);
    ui = U'(ai) + U'(ti);
    vr = U'(ar) - U'(tr);
    vi = U'(ai) - U'(ti);
    top_n = {SCALE ? H'(ur >>> 1) : H'(ur), SCALE ? H'(ui >>> 1) : H'(ui)};
    bot_n = {SCALE ? H'(vr >>> 1) : H'(vr), SCALE ? H'(vi >>> 1) : H'(vi)};
  end

  // sample store: bit-reversed writes while loading, both butterfly results per compute cycle
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem_q[bitrev(cnt_q)] <= in_data;
    if (state_q == COMPUTE) begin
      mem_q[top] <= top_n;
      mem_q[bot] <= bot_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bfly_q <= '0;
      stage_q <= '0;
      inv_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          inv_q <= in_inverse;
          cnt_q <= L'(1);
          state_q <= LOAD;
        end
        LOAD: if (in_valid) begin
          cnt_q <= cnt_q + L'(1);
          if (cnt_q == L'(SAMPLES - 1)) state_q <= COMPUTE;
        end
        COMPUTE: begin
          bfly_q <= bfly_q + BW'(1);
          if (&bfly_q) begin
            stage_q <= stage_q + SW'(1);
            if (stage_q == SW'(L - 1)) begin
              stage_q <= '0;
              state_q <= UNLOAD;
            end
          end
        end
        default: if (!out_valid_q) begin
          // first UNLOAD cycle primes bin 0 into the output register
          out_valid_q <= 1'b1;
          out_data_q <= mem_q[0];
        end else if (out_ready) begin
          if (out_last_q) begin
            state_q <= IDLE;
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + L'(1);
            out_data_q <= mem_q[cnt_q + L'(1)];
            out_last_q <= cnt_q == L'(SAMPLES - 2);
          end
        end
      endcase
    end
  end
endmodule
